// File: rtl/eu_icon_rdarb_pkg.sv
// Shared types for the EU interconnect read-port arbiter.
// Build option: EU_RDARB_RETRY_LIMIT_EN (see eu_icon_rdarb.sv).
package eu_icon_rdarb_pkg;

    localparam int unsigned EXEC_UNIT_ADDR_W = 16;
    localparam int unsigned EXEC_UNIT_DATA_W = 32;

    typedef logic [EXEC_UNIT_ADDR_W-1:0] type_exec_unit_addr;
    typedef logic [EXEC_UNIT_DATA_W-1:0] type_exec_unit_data;

    typedef enum logic {
        ARB_IDLE  = 1'b0,
        ARB_GRANT = 1'b1
    } type_eu_rdarb_state;

endpackage

// File: rtl/eu_rr_picker.sv
// Combinational round-robin picker: first requesting, unmasked index
// found searching upward from ptr_i, wrapping at NUM_REQ-1.
module eu_rr_picker #(
    parameter int unsigned NUM_REQ = 4,
    parameter int unsigned PTR_W   = $clog2(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] req_i,
    input  logic [NUM_REQ-1:0] mask_i,
    input  logic [PTR_W-1:0]   ptr_i,
    output logic               hit_o,
    output logic [PTR_W-1:0]   idx_o
);

    logic [PTR_W:0] w_pos;

    // Scan all candidates in priority order starting at the pointer
    always_comb begin
        hit_o = 1'b0;
        idx_o = '0;
        w_pos = '0;
        for (int unsigned k = 0; k < NUM_REQ; k++) begin
            w_pos = {1'b0, ptr_i} + (PTR_W+1)'(k);
            if (w_pos >= (PTR_W+1)'(NUM_REQ)) begin
                w_pos = w_pos - (PTR_W+1)'(NUM_REQ);
            end
            if (!hit_o && req_i[w_pos[PTR_W-1:0]] && !mask_i[w_pos[PTR_W-1:0]]) begin
                hit_o = 1'b1;
                idx_o = w_pos[PTR_W-1:0];
            end
        end
    end

endmodule

// File: rtl/eu_icon_rdarb.sv
// Round-robin arbiter sharing the EU cache tx X-buffer read port among
// NUM_REQ foreign requesters. One request is latched at a time, retried on
// miss, and answered with a one-cycle response pulse.
// Build option: EU_RDARB_RETRY_LIMIT_EN forfeits a grant after RETRY_LIMIT
// consecutive misses; without it the grant is held until hit or withdrawal.
`ifndef EU_RDARB_NUM_REQ
`define EU_RDARB_NUM_REQ 4
`endif

module eu_icon_rdarb
    import eu_icon_rdarb_pkg::*;
#(
    parameter int unsigned NUM_REQ     = `EU_RDARB_NUM_REQ,
    parameter int unsigned RETRY_LIMIT = 8
) (
    input  logic                             clk,
    input  logic                             reset,
    input  logic [NUM_REQ-1:0]               req_valid_i,
    input  type_exec_unit_addr [NUM_REQ-1:0] req_addr_i,
    output logic [NUM_REQ-1:0]               resp_valid_o,
    output logic [NUM_REQ-1:0]               resp_retry_o,
    output type_exec_unit_data               resp_data_o,
    output type_exec_unit_addr               icon_raddr_o,
    output logic                             icon_rvalid_o,
    input  type_exec_unit_data               icon_rdata_i,
    input  logic                             icon_rsuccess_i,
    output logic                             busy_o
);

    localparam int unsigned PTR_W = $clog2(NUM_REQ);

    type_eu_rdarb_state r_state, w_state_nxt;
    logic [PTR_W-1:0]   r_ptr, r_gidx;
    logic [PTR_W-1:0]   w_gidx_inc, w_pick_ptr, w_pick_idx, w_ptr_nxt;
    logic [NUM_REQ-1:0] w_gsel, w_pick_mask, w_resp_valid_nxt;
    logic [NUM_REQ-1:0] r_resp_valid;
    type_exec_unit_addr r_gaddr;
    type_exec_unit_data r_resp_data;
    logic               r_active;
    logic               w_hit, w_grant, w_withdraw, w_limit, w_done, w_load, w_take_data;

    assign w_grant    = (r_state == ARB_GRANT);
    assign w_gsel     = NUM_REQ'(1) << r_gidx;
    assign w_gidx_inc = (r_gidx == PTR_W'(NUM_REQ-1)) ? '0 : r_gidx + PTR_W'(1);
    assign w_withdraw = w_grant && !req_valid_i[r_gidx];
    assign w_done     = w_grant && !w_withdraw && (icon_rsuccess_i || w_limit);

    // In IDLE pick from the pointer; in GRANT pre-compute the completion re-pick
    assign w_pick_ptr  = w_grant ? w_gidx_inc : r_ptr;
    assign w_pick_mask = w_grant ? w_gsel : '0;

    eu_rr_picker #(
        .NUM_REQ (NUM_REQ),
        .PTR_W   (PTR_W)
    ) u_picker (
        .req_i  (req_valid_i),
        .mask_i (w_pick_mask),
        .ptr_i  (w_pick_ptr),
        .hit_o  (w_hit),
        .idx_o  (w_pick_idx)
    );

`ifdef EU_RDARB_RETRY_LIMIT_EN
    localparam int unsigned RCNT_W = $clog2(RETRY_LIMIT+1);

    logic [RCNT_W-1:0]  r_rcnt, w_rcnt_nxt;
    logic [NUM_REQ-1:0] r_resp_retry, w_resp_retry_nxt;

    assign w_limit = (r_rcnt == RCNT_W'(RETRY_LIMIT-1));

    // Miss counter and forfeit pulse
    always_comb begin
        w_rcnt_nxt       = r_rcnt;
        w_resp_retry_nxt = '0;
        if (w_load) begin
            w_rcnt_nxt = '0;
        end else if (w_grant && !w_withdraw && !icon_rsuccess_i) begin
            w_rcnt_nxt = r_rcnt + RCNT_W'(1);
        end
        if (w_done && !icon_rsuccess_i) begin
            w_resp_retry_nxt = w_gsel;
        end
    end

    // Retry state registers
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_rcnt       <= '0;
            r_resp_retry <= '0;
        end else begin
            r_rcnt       <= w_rcnt_nxt;
            r_resp_retry <= w_resp_retry_nxt;
        end
    end

    assign resp_retry_o = r_resp_retry;
`else
    assign w_limit = 1'b0;
    // Legal RETRY_LIMIT is at least 1, so this ties the forfeit pulses low
    assign resp_retry_o = {NUM_REQ{RETRY_LIMIT == 0}};
`endif

    // FSM state register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= ARB_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // FSM next state: withdrawal wins over completion; completion re-picks
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ARB_IDLE: begin
                if (w_hit) w_state_nxt = ARB_GRANT;
            end
            ARB_GRANT: begin
                if (w_withdraw || (w_done && !w_hit)) w_state_nxt = ARB_IDLE;
            end
            default: w_state_nxt = ARB_IDLE;
        endcase
    end

    // FSM outputs: grant load, pointer advance, response pulse
    always_comb begin
        w_load           = 1'b0;
        w_ptr_nxt        = r_ptr;
        w_resp_valid_nxt = '0;
        w_take_data      = 1'b0;
        case (r_state)
            ARB_IDLE: begin
                w_load = w_hit;
            end
            ARB_GRANT: begin
                if (w_withdraw) begin
                    w_ptr_nxt = w_gidx_inc;
                end else if (w_done) begin
                    w_ptr_nxt = w_gidx_inc;
                    w_load    = w_hit;
                    if (icon_rsuccess_i) begin
                        w_resp_valid_nxt = w_gsel;
                        w_take_data      = 1'b1;
                    end
                end
            end
            default: ;
        endcase
    end

    // Grant latches, pointer and registered outputs
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_ptr        <= '0;
            r_gidx       <= '0;
            r_gaddr      <= '0;
            r_active     <= 1'b0;
            r_resp_valid <= '0;
            r_resp_data  <= '0;
        end else begin
            r_ptr        <= w_ptr_nxt;
            r_active     <= (w_state_nxt == ARB_GRANT);
            r_resp_valid <= w_resp_valid_nxt;
            if (w_load) begin
                r_gidx  <= w_pick_idx;
                r_gaddr <= req_addr_i[w_pick_idx];
            end
            if (w_take_data) begin
                r_resp_data <= icon_rdata_i;
            end
        end
    end

    assign resp_valid_o  = r_resp_valid;
    assign resp_data_o   = r_resp_data;
    assign icon_raddr_o  = r_gaddr;
    assign icon_rvalid_o = r_active;
    assign busy_o        = r_active;

endmodule

// File: tb/tb_eu_icon_rdarb.sv
// Directed bench for eu_icon_rdarb (NUM_REQ=4, RETRY_LIMIT=4).
module tb_eu_icon_rdarb;
    import eu_icon_rdarb_pkg::*;

    logic                     clk = 1'b0;
    logic                     reset;
    logic [3:0]               req_valid_i;
    type_exec_unit_addr [3:0] req_addr_i;
    logic [3:0]               resp_valid_o;
    logic [3:0]               resp_retry_o;
    type_exec_unit_data       resp_data_o;
    type_exec_unit_addr       icon_raddr_o;
    logic                     icon_rvalid_o;
    type_exec_unit_data       icon_rdata_i;
    logic                     icon_rsuccess_i;
    logic                     busy_o;

    int n_chk  = 0;
    int n_pass = 0;

    eu_icon_rdarb #(.NUM_REQ(4), .RETRY_LIMIT(4)) dut (
        .clk             (clk),
        .reset           (reset),
        .req_valid_i     (req_valid_i),
        .req_addr_i      (req_addr_i),
        .resp_valid_o    (resp_valid_o),
        .resp_retry_o    (resp_retry_o),
        .resp_data_o     (resp_data_o),
        .icon_raddr_o    (icon_raddr_o),
        .icon_rvalid_o   (icon_rvalid_o),
        .icon_rdata_i    (icon_rdata_i),
        .icon_rsuccess_i (icon_rsuccess_i),
        .busy_o          (busy_o)
    );

    always #5 clk = ~clk;

    // Advance one cycle; outputs are stable and inputs may be changed afterwards
    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset;
        reset = 1'b1;
        req_valid_i = '0;
        icon_rsuccess_i = 1'b0;
        tick();
        reset = 1'b0;
    endtask

    task automatic test_reset;
        reset = 1'b1;
        req_valid_i = 4'hF;
        icon_rsuccess_i = 1'b1;
        for (int i = 0; i < 4; i++) req_addr_i[i] = 16'h0100 + 16'(i);
        tick();
        tick();
        n_chk++; if (resp_valid_o !== 4'b0) $display("FAIL reset_resp_valid: got %b want 0000", resp_valid_o); else n_pass++;
        n_chk++; if (resp_retry_o !== 4'b0) $display("FAIL reset_resp_retry: got %b want 0000", resp_retry_o); else n_pass++;
        n_chk++; if (resp_data_o !== 32'h0) $display("FAIL reset_resp_data: got %h want 0", resp_data_o); else n_pass++;
        n_chk++; if (icon_rvalid_o !== 1'b0) $display("FAIL reset_rvalid: got %b want 0", icon_rvalid_o); else n_pass++;
        n_chk++; if (icon_raddr_o !== 16'h0) $display("FAIL reset_raddr: got %h want 0", icon_raddr_o); else n_pass++;
        n_chk++; if (busy_o !== 1'b0) $display("FAIL reset_busy: got %b want 0", busy_o); else n_pass++;
        icon_rsuccess_i = 1'b0;
        reset = 1'b0;
        tick();
        n_chk++; if (icon_rvalid_o !== 1'b1) $display("FAIL first_grant_rvalid: got %b want 1", icon_rvalid_o); else n_pass++;
        n_chk++; if (icon_raddr_o !== 16'h0100) $display("FAIL first_grant_idx0: got %h want 0100", icon_raddr_o); else n_pass++;
        n_chk++; if (busy_o !== 1'b1) $display("FAIL first_grant_busy: got %b want 1", busy_o); else n_pass++;
        do_reset();
    endtask

    task automatic test_single;
        req_addr_i[1] = 16'hA5A5;
        icon_rdata_i = 32'hDEAD_BEEF;
        icon_rsuccess_i = 1'b1;
        req_valid_i = 4'b0010;
        tick();
        n_chk++; if (icon_rvalid_o !== 1'b1) $display("FAIL single_c1_rvalid: got %b want 1", icon_rvalid_o); else n_pass++;
        n_chk++; if (icon_raddr_o !== 16'hA5A5) $display("FAIL single_c1_raddr: got %h want a5a5", icon_raddr_o); else n_pass++;
        n_chk++; if (resp_valid_o !== 4'b0) $display("FAIL single_c1_resp: got %b want 0000", resp_valid_o); else n_pass++;
        tick();
        n_chk++; if (resp_valid_o !== 4'b0010) $display("FAIL single_c2_resp: got %b want 0010", resp_valid_o); else n_pass++;
        n_chk++; if (resp_data_o !== 32'hDEAD_BEEF) $display("FAIL single_c2_data: got %h want deadbeef", resp_data_o); else n_pass++;
        n_chk++; if (icon_rvalid_o !== 1'b0) $display("FAIL single_c2_idle: got %b want 0", icon_rvalid_o); else n_pass++;
        req_valid_i = 4'b0;
        tick();
        n_chk++; if (resp_valid_o !== 4'b0) $display("FAIL single_c3_pulse_width: got %b want 0000", resp_valid_o); else n_pass++;
        n_chk++; if (icon_rvalid_o !== 1'b0) $display("FAIL single_c3_no_regrant: got %b want 0", icon_rvalid_o); else n_pass++;
        do_reset();
    endtask

    task automatic test_back_to_back;
        logic [3:0] e_valid;
        for (int i = 0; i < 4; i++) req_addr_i[i] = 16'h0200 + 16'(i);
        req_valid_i = 4'hF;
        icon_rsuccess_i = 1'b1;
        tick();
        n_chk++; if (icon_raddr_o !== 16'h0200) $display("FAIL rr_c1_raddr: got %h want 0200", icon_raddr_o); else n_pass++;
        for (int c = 1; c <= 8; c++) begin
            icon_rdata_i = 32'h1000 + 32'((c-1) % 4);
            tick();
            e_valid = 4'b0001 << ((c-1) % 4);
            n_chk++; if (resp_valid_o !== e_valid) $display("FAIL rr_resp_c%0d: got %b want %b", c+1, resp_valid_o, e_valid); else n_pass++;
            n_chk++; if (resp_data_o !== 32'h1000 + 32'((c-1) % 4)) $display("FAIL rr_data_c%0d: got %h want %h", c+1, resp_data_o, 32'h1000 + 32'((c-1) % 4)); else n_pass++;
            n_chk++; if (icon_raddr_o !== 16'h0200 + 16'(c % 4)) $display("FAIL rr_raddr_c%0d: got %h want %h", c+1, icon_raddr_o, 16'h0200 + 16'(c % 4)); else n_pass++;
        end
        do_reset();
    endtask

`ifdef EU_RDARB_RETRY_LIMIT_EN
    task automatic test_retry_limit;
        req_addr_i[2] = 16'h0300;
        req_addr_i[3] = 16'h0333;
        icon_rsuccess_i = 1'b0;
        req_valid_i = 4'b0100;
        tick();
        req_valid_i = 4'b1100;
        for (int c = 1; c <= 4; c++) begin
            n_chk++; if (resp_retry_o !== 4'b0 || icon_raddr_o !== 16'h0300 || icon_rvalid_o !== 1'b1)
                $display("FAIL retry_hold_c%0d: got retry=%b raddr=%h rvalid=%b want 0000/0300/1", c, resp_retry_o, icon_raddr_o, icon_rvalid_o);
            else n_pass++;
            tick();
        end
        n_chk++; if (resp_retry_o !== 4'b0100) $display("FAIL retry_pulse: got %b want 0100", resp_retry_o); else n_pass++;
        n_chk++; if (resp_valid_o !== 4'b0) $display("FAIL retry_no_valid: got %b want 0000", resp_valid_o); else n_pass++;
        n_chk++; if (icon_raddr_o !== 16'h0333) $display("FAIL retry_next_grant: got %h want 0333", icon_raddr_o); else n_pass++;
        req_valid_i = 4'b1000;
        icon_rsuccess_i = 1'b1;
        icon_rdata_i = 32'h3333_0003;
        tick();
        n_chk++; if (resp_valid_o !== 4'b1000 || resp_retry_o !== 4'b0) $display("FAIL retry_then_hit: got valid=%b retry=%b want 1000/0000", resp_valid_o, resp_retry_o); else n_pass++;
        do_reset();
    endtask
`else
    task automatic test_no_retry_limit;
        req_addr_i[2] = 16'h0300;
        icon_rsuccess_i = 1'b0;
        req_valid_i = 4'b0100;
        tick();
        for (int c = 1; c <= 10; c++) begin
            n_chk++; if (icon_rvalid_o !== 1'b1 || icon_raddr_o !== 16'h0300 || resp_retry_o !== 4'b0 || resp_valid_o !== 4'b0)
                $display("FAIL hold_c%0d: got rvalid=%b raddr=%h retry=%b valid=%b want 1/0300/0000/0000", c, icon_rvalid_o, icon_raddr_o, resp_retry_o, resp_valid_o);
            else n_pass++;
            if (c == 3) req_addr_i[2] = 16'h03FF;
            if (c == 10) begin
                icon_rsuccess_i = 1'b1;
                icon_rdata_i = 32'h0000_CAFE;
            end
            tick();
        end
        n_chk++; if (resp_valid_o !== 4'b0100) $display("FAIL hold_c11_resp: got %b want 0100", resp_valid_o); else n_pass++;
        n_chk++; if (resp_data_o !== 32'h0000_CAFE) $display("FAIL hold_c11_data: got %h want 0000cafe", resp_data_o); else n_pass++;
        n_chk++; if (resp_retry_o !== 4'b0) $display("FAIL hold_c11_retry: got %b want 0000", resp_retry_o); else n_pass++;
        do_reset();
    endtask
`endif

    task automatic test_withdraw;
        req_addr_i[0] = 16'h0400;
        req_addr_i[1] = 16'h0411;
        icon_rsuccess_i = 1'b0;
        req_valid_i = 4'b0011;
        tick();
        n_chk++; if (icon_raddr_o !== 16'h0400) $display("FAIL wd_c1_grant0: got %h want 0400", icon_raddr_o); else n_pass++;
        tick();
        // Withdraw and hit in the same cycle: withdrawal wins
        req_valid_i = 4'b0010;
        icon_rsuccess_i = 1'b1;
        icon_rdata_i = 32'h4444_0000;
        tick();
        n_chk++; if (resp_valid_o !== 4'b0 || icon_rvalid_o !== 1'b0) $display("FAIL wd_c3_abort: got valid=%b rvalid=%b want 0000/0", resp_valid_o, icon_rvalid_o); else n_pass++;
        icon_rdata_i = 32'h4444_0001;
        tick();
        n_chk++; if (icon_rvalid_o !== 1'b1 || icon_raddr_o !== 16'h0411) $display("FAIL wd_c4_grant1: got rvalid=%b raddr=%h want 1/0411", icon_rvalid_o, icon_raddr_o); else n_pass++;
        n_chk++; if (resp_valid_o !== 4'b0) $display("FAIL wd_c4_no_resp0: got %b want 0000", resp_valid_o); else n_pass++;
        tick();
        n_chk++; if (resp_valid_o !== 4'b0010 || resp_data_o !== 32'h4444_0001) $display("FAIL wd_c5_resp1: got %b/%h want 0010/44440001", resp_valid_o, resp_data_o); else n_pass++;
        do_reset();
    endtask

    task automatic test_mid_reset;
        req_addr_i[0] = 16'h0500;
        icon_rsuccess_i = 1'b0;
        req_valid_i = 4'b0001;
        tick();
        n_chk++; if (icon_rvalid_o !== 1'b1) $display("FAIL mr_grant: got %b want 1", icon_rvalid_o); else n_pass++;
        reset = 1'b1;
        #1;
        n_chk++; if (icon_rvalid_o !== 1'b0 || busy_o !== 1'b0) $display("FAIL mr_async: got rvalid=%b busy=%b want 0/0", icon_rvalid_o, busy_o); else n_pass++;
        req_valid_i = 4'b0;
        icon_rsuccess_i = 1'b1;
        tick();
        reset = 1'b0;
        tick();
        n_chk++; if (resp_valid_o !== 4'b0 || icon_rvalid_o !== 1'b0) $display("FAIL mr_dropped: got valid=%b rvalid=%b want 0000/0", resp_valid_o, icon_rvalid_o); else n_pass++;
    endtask

    initial begin
        reset = 1'b1;
        req_valid_i = '0;
        req_addr_i = '0;
        icon_rdata_i = '0;
        icon_rsuccess_i = 1'b0;
        test_reset();
        test_single();
        test_back_to_back();
`ifdef EU_RDARB_RETRY_LIMIT_EN
        test_retry_limit();
`else
        test_no_retry_limit();
`endif
        test_withdraw();
        test_mid_reset();
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
